return_stack: RTL and testbench

- Hardware return-address stack that produces the stack address consumed by the next-PC selector when it takes its stack path (PCoper_i = 2'b10 with PCoper_i[1] = 1).
- Captures return addresses on CALL and on interrupt entry, and exposes the top of stack as `stk_o`.
- Pops on RET/RETI. The carry and zero flags saved on interrupt entry are returned for restore on RETI.
- Sits beside the PC register; the control unit drives the push and pop strobes.

---
 rtl/return_stack.sv | 114 +++++++++++
 tb/tb_return_stack.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/return_stack.sv
// Hardware return-address stack feeding the next-PC stack path.
// Entries are {carry, zero, addr}. Outputs are combinational from the top entry.

module rs_entry #(
  parameter int W = 14
) (
  input  logic         clk_i,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // No reset: an entry is only visible once sp covers it.
  always_ff @(posedge clk_i) begin
    if (we) q <= d;
  end
endmodule

module return_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] pc_i,
  input  logic          call_i,
  input  logic          int_i,
  input  logic          pop_i,
  input  logic          zero_i,
  input  logic          carry_i,
  input  logic          clr_err_i,
  output logic [AW-1:0] stk_o,
  output logic          zero_o,
  output logic          carry_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          ovf_o,
  output logic          unf_o
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW  = AW + 2;

  typedef struct packed {
    logic          carry;
    logic          zero;
    logic [AW-1:0] addr;
  } entry_t;

  logic [SPW-1:0]         sp;
  logic [DEPTH-1:0][EW-1:0] ent_q;
  logic [DEPTH-1:0]       ent_we;
  entry_t                 wr_ent, top;
  logic [IW-1:0]          wr_idx, rd_idx;
  logic                   push, empty, full;
  logic                   do_replace, do_push, do_pop, ovf_set, unf_set;

  assign push  = call_i | int_i;
  assign empty = (sp == '0);
  assign full  = (sp == SPW'(DEPTH));

  // Interrupt entry wins over a coincident call and saves pc_i unmodified.
  assign wr_ent.carry = carry_i;
  assign wr_ent.zero  = zero_i;
  assign wr_ent.addr  = int_i ? pc_i : pc_i + AW'(1);

  // Push+pop on a non-empty stack is a tail call: overwrite the top, even when full.
  assign do_replace = push & pop_i & ~empty;
  assign do_push    = push & ~do_replace & ~full;
  assign do_pop     = pop_i & ~push & ~empty;
  assign ovf_set    = push & ~pop_i & full;
  assign unf_set    = pop_i & empty;

  assign rd_idx = IW'(sp - SPW'(1));
  assign wr_idx = do_replace ? rd_idx : IW'(sp);

  always_comb begin
    ent_we = '0;
    if (do_replace | do_push) ent_we[wr_idx] = 1'b1;
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      rs_entry #(.W(EW)) u_ent (
        .clk_i (clk_i),
        .we    (ent_we[g]),
        .d     (wr_ent),
        .q     (ent_q[g])
      );
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sp    <= '0;
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else begin
      if (do_push)     sp <= sp + SPW'(1);
      else if (do_pop) sp <= sp - SPW'(1);
      // A new error event takes precedence over a clear in the same cycle.
      ovf_o <= ovf_set | (ovf_o & ~clr_err_i);
      unf_o <= unf_set | (unf_o & ~clr_err_i);
    end
  end

  // Empty forces zeros so never-written entries cannot leak X.
  assign top     = empty ? entry_t'('0) : entry_t'(ent_q[rd_idx]);
  assign stk_o   = top.addr;
  assign zero_o  = top.zero;
  assign carry_o = top.carry;
  assign empty_o = empty;
  assign full_o  = full;
endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack with hand-computed expectations.

module tb_return_stack;
  localparam int DEPTH = 8;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          rst, call, intr, pop, zero, carry, clr;
  logic [AW-1:0] pc;
  logic [AW-1:0] stk;
  logic          zero_o, carry_o, empty, full, ovf, unf;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .pc_i      (pc),
    .call_i    (call),
    .int_i     (intr),
    .pop_i     (pop),
    .zero_i    (zero),
    .carry_i   (carry),
    .clr_err_i (clr),
    .stk_o     (stk),
    .zero_o    (zero_o),
    .carry_o   (carry_o),
    .empty_o   (empty),
    .full_o    (full),
    .ovf_o     (ovf),
    .unf_o     (unf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; call = 0; intr = 0; pop = 0; zero = 0; carry = 0; clr = 0; pc = '0;
  endtask

  // Apply current inputs for one edge, return inputs to idle, sample after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_call(input logic [AW-1:0] a, input logic z, input logic c);
    call = 1; pc = a; zero = z; carry = c;
    step();
  endtask

  task automatic do_pop();
    pop = 1;
    step();
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    chk("rst_empty", empty, 1);
    chk("rst_stk",   stk,   0);
    chk("rst_full",  full,  0);
    chk("rst_ovf",   ovf,   0);
    chk("rst_unf",   unf,   0);

    // 1: single call/pop
    do_call(12'h123, 1, 0);
    chk("t1_stk",   stk,     12'h124);
    chk("t1_zero",  zero_o,  1);
    chk("t1_carry", carry_o, 0);
    chk("t1_empty", empty,   0);
    do_pop();
    chk("t1_pop_empty", empty, 1);
    chk("t1_pop_stk",   stk,   0);

    // 2: LIFO ordering
    do_call(12'h010, 0, 0);
    do_call(12'h020, 0, 0);
    do_call(12'h030, 0, 0);
    chk("t2_top", stk, 12'h031);
    do_pop(); chk("t2_pop1", stk, 12'h021);
    do_pop(); chk("t2_pop2", stk, 12'h011);
    do_pop(); chk("t2_pop3", stk, 0);
    chk("t2_empty", empty, 1);

    // 3: fill, overflow, clear, replace while full
    for (int i = 0; i < DEPTH; i++) do_call(AW'(12'h100 + i), 0, 0);
    chk("t3_full",     full, 1);
    chk("t3_ovf_pre",  ovf,  0);
    chk("t3_top",      stk,  12'h108);
    do_call(12'h3F0, 0, 0);
    chk("t3_ovf",      ovf,  1);
    chk("t3_full2",    full, 1);
    chk("t3_top_keep", stk,  12'h108);
    clr = 1; step();
    chk("t3_clr_ovf",  ovf,  0);
    chk("t3_clr_full", full, 1);
    call = 1; pop = 1; pc = 12'h400; step();
    chk("t3_rep_stk",  stk,  12'h401);
    chk("t3_rep_full", full, 1);
    chk("t3_rep_ovf",  ovf,  0);
    for (int i = 0; i < DEPTH - 1; i++) do_pop();
    chk("t3_drain_stk", stk, 12'h101);
    do_pop();
    chk("t3_drain_empty", empty, 1);

    // 4: underflow, sticky, clear-vs-event, reset mid-sequence
    do_pop();
    chk("t4_unf",   unf,   1);
    chk("t4_empty", empty, 1);
    pop = 1; clr = 1; step();
    chk("t4_clr_vs_evt", unf, 1);
    do_call(12'h001, 0, 0);
    do_call(12'h002, 0, 0);
    do_call(12'h003, 0, 0);
    chk("t4_sticky", unf, 1);
    chk("t4_top",    stk, 12'h004);
    rst = 1; call = 1; pc = 12'h555; step();
    chk("t4_rst_empty", empty, 1);
    chk("t4_rst_unf",   unf,   0);
    chk("t4_rst_stk",   stk,   0);

    // 5: wrap, interrupt priority, interrupt-only
    do_call(12'hFFF, 0, 0);
    chk("t5_wrap", stk, 12'h000);
    chk("t5_wrap_empty", empty, 0);
    do_pop();
    call = 1; intr = 1; pc = 12'h200; carry = 1; step();
    chk("t5_int_stk",   stk,     12'h200);
    chk("t5_int_carry", carry_o, 1);
    do_pop();
    chk("t5_one_entry", empty, 1);
    intr = 1; pc = 12'h300; zero = 1; step();
    chk("t5_intonly_stk",  stk,     12'h300);
    chk("t5_intonly_zero", zero_o,  1);
    chk("t5_intonly_c",    carry_o, 0);
    do_pop();

    // 6: tail call replace
    do_call(12'h010, 0, 0);
    do_call(12'h020, 0, 0);
    call = 1; pop = 1; pc = 12'h050; step();
    chk("t6_rep_stk", stk, 12'h051);
    do_pop();
    chk("t6_pop_stk", stk, 12'h011);
    do_pop();
    chk("t6_sp2_empty", empty, 1);

    // push+pop on empty: acts as push and flags underflow
    clr = 1; step();
    call = 1; pop = 1; pc = 12'h070; step();
    chk("t7_stk",   stk,   12'h071);
    chk("t7_unf",   unf,   1);
    chk("t7_empty", empty, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
